// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one combinational ALU between two
// requesters with registered operand drive, settle wait and tagged response.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready [1:0]  per-requester handshake
//   req{0,1}_a/_b/_op/_cin     operands, {mode,sel} opcode, active-high carry
//   alu_a/_b/_mode/_sel        registered ALU operand/opcode drive
//   alu_cin_n                  registered ALU carry in, active-low
//   alu_result, alu_cout_n     ALU result and active-low carry out
//   rsp_valid/rsp_ready        response handshake
//   rsp_id/_result/_cout       requester tag, captured result, active-high carry
// Optional: ALU_ARB_STATS_EN adds saturating grant_cnt0/grant_cnt1 outputs.
module alu_share_arbiter #(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_WIDTH     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [4:0]       req0_op,
  input  logic [4:0]       req1_op,
  input  logic             req0_cin,
  input  logic             req1_cin,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_mode,
  output logic [3:0]       alu_sel,
  output logic             alu_cin_n,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout_n,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_cout
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] grant_cnt0,
  output logic [CNT_WIDTH-1:0] grant_cnt1
`endif
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t          state;
  logic            last_grant;
  logic [SW-1:0]   cnt;
  logic            any;
  logic            grant;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [4:0]      sel_op;
  logic            sel_cin;

  // A lone valid port wins outright; a tie goes to the port not served last.
  always_comb begin
    any       = |req_valid;
    grant     = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    req_ready = 2'b00;
    if (state == IDLE && any) req_ready[grant] = 1'b1;
    sel_a     = grant ? req1_a   : req0_a;
    sel_b     = grant ? req1_b   : req0_b;
    sel_op    = grant ? req1_op  : req0_op;
    sel_cin   = grant ? req1_cin : req0_cin;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_mode   <= 1'b0;
      alu_sel    <= 4'd0;
      alu_cin_n  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_cout   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            state      <= DRIVE;
            alu_a      <= sel_a;
            alu_b      <= sel_b;
            alu_mode   <= sel_op[4];
            alu_sel    <= sel_op[3:0];
            alu_cin_n  <= ~sel_cin;
            rsp_id     <= grant;
            last_grant <= grant;
            cnt        <= '0;
          end
        end
        DRIVE: begin
          if (cnt == LAST) begin
            rsp_result <= alu_result;
            rsp_cout   <= ~alu_cout_n;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req_ready[0] && req_valid[0] && grant_cnt0 != '1)
        grant_cnt0 <= grant_cnt0 + 1'b1;
      if (req_ready[1] && req_valid[1] && grant_cnt1 != '1)
        grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: transaction-level model of the shared-ALU arbiter
// with a behavioural ALU that only settles after the held-input time.
module tb_alu_share_arbiter;
  localparam int W  = 16;
  localparam int S  = 2;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [4:0] ADD_OP = 5'b0_1001;
  localparam logic [4:0] SUB_OP = 5'b0_0110;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_ready;
  logic [W-1:0]  req0_a = '0, req1_a = '0, req0_b = '0, req1_b = '0;
  logic [4:0]    req0_op = '0, req1_op = '0;
  logic          req0_cin = 1'b0, req1_cin = 1'b0;
  logic [W-1:0]  alu_a, alu_b, alu_result;
  logic          alu_mode, alu_cin_n, alu_cout_n;
  logic [3:0]    alu_sel;
  logic          rsp_valid, rsp_id, rsp_cout;
  logic          rsp_ready = 1'b0;
  logic [W-1:0]  rsp_result;
`ifdef ALU_ARB_STATS_EN
  logic [CW-1:0] grant_cnt0, grant_cnt1;
`endif

  alu_share_arbiter #(.WIDTH(W), .SETTLE_CYCLES(S), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_cin(req0_cin), .req1_cin(req1_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_sel(alu_sel),
    .alu_cin_n(alu_cin_n), .alu_result(alu_result), .alu_cout_n(alu_cout_n),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_cout(rsp_cout)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  always #5 clk = ~clk;

  // Reference ALU: returns {cout_n, result}; cin active-high.
  function automatic logic [16:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [4:0] op, input logic cin);
    logic [16:0] s;
    if (op[4]) begin
      s[15:0] = (a & b) ^ {4{op[3:0]}};
      s[16]   = a[15] ^ b[0];
    end else if (op[3:0] == 4'h9) begin
      s = {1'b0, a} + {1'b0, b} + 17'(cin);
      s[16] = ~s[16];
    end else if (op[3:0] == 4'h6) begin
      s = {1'b0, a} + {1'b0, ~b} + 17'(cin);
    end else begin
      s = {1'b0, a} + {1'b0, b ^ {4{op[3:0]}}} + 17'(cin);
      s[16] = ~s[16];
    end
    return s;
  endfunction

  // ALU output is corrupted until its inputs have been held S edges.
  logic [37:0] alu_in, alu_prev = '0;
  int          held = 0;
  logic [16:0] alu_out;
  assign alu_in = {alu_a, alu_b, alu_mode, alu_sel, alu_cin_n};
  always @(negedge clk) begin
    if (alu_in != alu_prev) begin
      alu_prev <= alu_in;
      held     <= 1;
    end else if (held < 1000) begin
      held <= held + 1;
    end
  end
  always_comb begin
    alu_out = alu_fn(alu_a, alu_b, {alu_mode, alu_sel}, ~alu_cin_n);
    if (held < S) alu_out = ~alu_out;
  end
  assign alu_result = alu_out[15:0];
  assign alu_cout_n = alu_out[16];

  int checks = 0;
  int errors = 0;

  // Requester side
  bit          pend [2] = '{0, 0};
  logic [15:0] ra [2], rb [2];
  logic [4:0]  rop [2];
  logic        rcin [2];

  // Transaction model
  bit          busy = 0;
  int          age = 0;
  int          last = 1;
  logic [15:0] m_a = '0, m_b = '0, m_res = '0;
  logic [4:0]  m_op = '0;
  logic        m_cinn = 1'b1, m_id = 1'b0, m_cout = 1'b0;
  int          gcnt [2] = '{0, 0};
  int          dlog [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic newreq(input int p, input logic [15:0] a, input logic [15:0] b,
                        input logic [4:0] op, input logic cin);
    pend[p] = 1; ra[p] = a; rb[p] = b; rop[p] = op; rcin[p] = cin;
  endtask

  task automatic rnd_req(input int p);
    newreq(p, 16'($urandom), 16'($urandom), 5'($urandom_range(31, 0)),
           1'($urandom_range(1, 0)));
  endtask

  task automatic apply();
    req_valid = {pend[1], pend[0]};
    req0_a = ra[0]; req0_b = rb[0]; req0_op = rop[0]; req0_cin = rcin[0];
    req1_a = ra[1]; req1_b = rb[1]; req1_op = rop[1]; req1_cin = rcin[1];
  endtask

  function automatic int pick();
    if (req_valid == 2'b11) return 1 - last;
    return req_valid[1] ? 1 : 0;
  endfunction

  task automatic check();
    logic [1:0] er;
    er = 2'b00;
    if (!busy && req_valid != 2'b00) er[pick()] = 1'b1;
    chk("req_ready", req_ready, er);
    chk("rsp_valid", rsp_valid, busy && age >= S);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_op", {alu_mode, alu_sel}, m_op);
    chk("alu_cin_n", alu_cin_n, m_cinn);
    if (busy && age >= S) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_result", rsp_result, m_res);
      chk("rsp_cout", rsp_cout, m_cout);
    end
`ifdef ALU_ARB_STATS_EN
    chk("grant_cnt0", grant_cnt0, gcnt[0]);
    chk("grant_cnt1", grant_cnt1, gcnt[1]);
`endif
    if (rst_n && req_ready != 2'b00) dlog.push_back(int'(req_ready[1]));
  endtask

  // What the next edge does, at transaction level.
  task automatic advance();
    int g;
    logic [16:0] f;
    if (!rst_n) begin
      busy = 0; last = 1;
      m_a = '0; m_b = '0; m_op = '0; m_cinn = 1'b1;
      gcnt[0] = 0; gcnt[1] = 0;
      return;
    end
    if (!busy) begin
      if (req_valid != 2'b00) begin
        g = pick();
        busy = 1; age = 0; last = g;
        m_a = ra[g]; m_b = rb[g]; m_op = rop[g]; m_cinn = ~rcin[g];
        m_id = 1'(g);
        f = alu_fn(ra[g], rb[g], rop[g], rcin[g]);
        m_res = f[15:0]; m_cout = ~f[16];
        pend[g] = 0;
        if (gcnt[g] < CMAX) gcnt[g]++;
      end
    end else if (age < S) begin
      age++;
    end else if (rsp_ready) begin
      busy = 0;
    end
  endtask

  task automatic step();
    apply();
    #1;
    check();
    advance();
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    rsp_ready = 1'b1;
    while ((busy || pend[0] || pend[1]) && n < 100) begin
      step();
      n++;
    end
    chk("drain_bound", n < 100, 1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!rsp_valid && n < 50) begin
      step();
      n++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    for (int p = 0; p < 2; p++) begin
      ra[p] = '0; rb[p] = '0; rop[p] = '0; rcin[p] = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    step();
    rst_n = 1'b1;
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_cout", rsp_cout, 0);
    chk("rst_alu_cin_n", alu_cin_n, 1);

    // ADD on port 0 with carry out
    rsp_ready = 1'b0;
    newreq(0, 16'hFFFF, 16'h0001, ADD_OP, 1'b0);
    step();
    chk("add_cin_n", alu_cin_n, 1);
    wait_valid(n);
    chk("add_latency", n, S);
    chk("add_id", rsp_id, 0);
    chk("add_result", rsp_result, 16'h0000);
    chk("add_cout", rsp_cout, 1);
    drain();

    // SUB on port 1 producing a borrow
    rsp_ready = 1'b0;
    newreq(1, 16'h0000, 16'h0001, SUB_OP, 1'b1);
    step();
    wait_valid(n);
    chk("sub_latency", n, S);
    chk("sub_id", rsp_id, 1);
    chk("sub_result", rsp_result, 16'hFFFF);
    chk("sub_cout", rsp_cout, 1);
    drain();

    // Both ports always requesting: grants alternate starting at port 0
    dlog.delete();
    rsp_ready = 1'b1;
    for (int k = 0; k < 200 && dlog.size() < 4; k++) begin
      for (int p = 0; p < 2; p++) if (!pend[p]) rnd_req(p);
      step();
    end
    chk("rr_count", dlog.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_grant%0d", i), (i < dlog.size()) ? dlog[i] : 99, i % 2);
    drain();

    // Response held off for 5 cycles while port 1 waits
    rsp_ready = 1'b0;
    rnd_req(0);
    step();
    wait_valid(n);
    rnd_req(1);
    for (int k = 0; k < 5; k++) step();
    chk("stall_ready", req_ready, 2'b00);
    rsp_ready = 1'b1;
    step();
    apply();
    #1;
    chk("resume_ready", req_ready, 2'b10);
    drain();

    // Reset while an operation is in DRIVE
    rsp_ready = 1'b0;
    rnd_req(0); rnd_req(1);
    step();
    do_reset();
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_cin_n", alu_cin_n, 1);
    for (int p = 0; p < 2; p++) if (!pend[p]) rnd_req(p);
    apply();
    #1;
    chk("post_rst_grant", req_ready, 2'b01);
    drain();

`ifdef ALU_ARB_STATS_EN
    do_reset();
    for (int k = 0; k < 5; k++) begin
      rnd_req(0);
      drain();
      if (k == 2) begin
        chk("stats_cnt0_3", grant_cnt0, 3);
        chk("stats_cnt1_0", grant_cnt1, 0);
      end
    end
    chk("stats_sat", grant_cnt0, 3);
`endif

    // Randomized traffic with random back-pressure and rare resets
    for (int k = 0; k < 3000; k++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p] && $urandom_range(1, 0) == 1) rnd_req(p);
      rsp_ready = ($urandom_range(3, 0) != 0);
      rst_n = ($urandom_range(199, 0) != 0);
      step();
    end
    rst_n = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
